// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
package uart_pkg;

  // Smallest bit period (in clocks) for which centre sampling still works.
  localparam int UART_MIN_PERIOD = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Clocks per bit, truncated; the transmitter uses the same rounding.
  function automatic int uart_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two flops in series give metastability time; both start at RESET_VAL.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: centre-sampled frames delivered through a one-entry
// valid/ready holding register, with framing-error and overrun pulses.
module uart_rx import uart_pkg::*; #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int PERIOD = uart_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF   = PERIOD / 2;
  localparam int CNT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 2;
  localparam int BIT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(PERIOD - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  if (PERIOD < UART_MIN_PERIOD) begin : g_bad_period
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx: STOP_BITS must be 1 or 2");
  end

  rx_state_t            state;
  rx_state_t            state_next;
  logic                 rx_s;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 stop_bad;
  logic                 tick_half;
  logic                 tick_full;
  logic                 sample_data;
  logic                 sample_stop;
  logic                 commit;
  logic                 frame_fail;

  // The line idles high, so the synchronizer resets to 1.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  assign tick_half = (cnt == CNT_HALF);
  assign tick_full = (cnt == CNT_FULL);

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle sampling strobes.
  always_comb begin
    state_next  = state;
    sample_data = 1'b0;
    sample_stop = 1'b0;
    commit      = 1'b0;
    frame_fail  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (tick_half) begin
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_full) begin
          sample_data = 1'b1;
          if (bit_cnt == LAST_DATA) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (tick_full) begin
          sample_stop = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            if (stop_bad || !rx_s) begin
              frame_fail = 1'b1;
              state_next = WAIT_IDLE;
            end else begin
              commit     = 1'b1;
              state_next = IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit timing: count clocks within a bit, restart on every state change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (state_next != state) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (state == DATA || state == STOP) begin
      if (tick_full) begin
        cnt     <= '0;
        bit_cnt <= bit_cnt + BIT_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else if (state == START) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt     <= '0;
      bit_cnt <= '0;
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift <= '0;
    end else if (sample_data) begin
      shift <= {rx_s, shift[DATA_BITS-1:1]};
    end
  end

  // Remember any low stop sample before the final one of the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stop_bad <= 1'b0;
    end else if (state != STOP) begin
      stop_bad <= 1'b0;
    end else if (sample_stop && !rx_s) begin
      stop_bad <= 1'b1;
    end
  end

  // Holding register: a commit always wins, even over a pending handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= frame_fail;
      overrun   <= 1'b0;
      if (commit) begin
        data       <= shift;
        data_valid <= 1'b1;
        overrun    <= data_valid && !data_ready;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
